// File: rtl/spike_rate_decoder_if.sv
// Handshake bundle for the spike rate decoder.
// master drives the request and spike stream; slave returns the results.
interface spike_rate_decoder_if #(
  parameter int WINDOW_LOG2 = 8,
  parameter int PROB_W      = 4
);
  logic                   start;
  logic                   en;
  logic                   spike_in;
  logic                   busy;
  logic                   done;
  logic [WINDOW_LOG2:0]   count_out;
  logic [PROB_W-1:0]      rate_out;

  modport master (
    output start, en, spike_in,
    input  busy, done, count_out, rate_out
  );

  modport slave (
    input  start, en, spike_in,
    output busy, done, count_out, rate_out
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over 2^WINDOW_LOG2 accepted samples and decodes a rate.
// Define SPIKE_RATE_DEC_CONT_EN for back-to-back continuous windows.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int PROB_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_rate_decoder_if.slave  bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam logic [WINDOW_LOG2-1:0] LAST = '1;

  logic [0:0]             state_q, state_d;
  logic [WINDOW_LOG2-1:0] sample_q, sample_d;
  logic [WINDOW_LOG2:0]   spike_q, spike_d;
  logic [WINDOW_LOG2:0]   count_q, count_d;
  logic [PROB_W-1:0]      rate_q, rate_d;
  logic                   done_q, done_d;
  logic [WINDOW_LOG2:0]   total;

  // Running count including the sample on this cycle
  assign total = spike_q + (WINDOW_LOG2+1)'(bus.spike_in);

  // Next-state: start clears, accepted samples count, last sample latches results
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    spike_d  = spike_q;
    count_d  = count_q;
    rate_d   = rate_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d  = MEASURE;
        sample_d = '0;
        spike_d  = '0;
      end
    end else if (bus.start) begin
      sample_d = '0;
      spike_d  = '0;
    end else if (bus.en) begin
      if (sample_q == LAST) begin
        count_d  = total;
        rate_d   = total[WINDOW_LOG2] ? '1
                 : total[WINDOW_LOG2-1 -: PROB_W];
        done_d   = 1'b1;
        sample_d = '0;
        spike_d  = '0;
`ifdef SPIKE_RATE_DEC_CONT_EN
        state_d  = MEASURE;
`else
        state_d  = IDLE;
`endif
      end else begin
        sample_d = sample_q + 1'b1;
        spike_d  = total;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      spike_q  <= '0;
      count_q  <= '0;
      rate_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      spike_q  <= spike_d;
      count_q  <= count_d;
      rate_q   <= rate_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q == MEASURE);
  assign bus.done      = done_q;
  assign bus.count_out = count_q;
  assign bus.rate_out  = rate_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder.
// Set SPIKE_RATE_DEC_CONT_EN to also cover continuous mode.
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ndone  = 0;

`ifdef SPIKE_RATE_DEC_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  spike_rate_decoder_if #(.WINDOW_LOG2(8), .PROB_W(4)) bus ();

  spike_rate_decoder #(.WINDOW_LOG2(8), .PROB_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input logic s, input logic e, input logic sp);
    bus.start    = s;
    bus.en       = e;
    bus.spike_in = sp;
    @(posedge clk);
    #1;
    if (bus.done) ndone++;
  endtask

  task automatic window(input int every, input int exp_cnt,
                        input int exp_rate, input string tag);
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    chk({tag, "_busy"}, int'(bus.busy), 1);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, every > 0 && (i % every == 0));
      if (i == 254) chk({tag, "_early"}, int'(bus.done), 0);
    end
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_busy_end"}, int'(bus.busy), CONT ? 1 : 0);
    chk({tag, "_count"}, int'(bus.count_out), exp_cnt);
    chk({tag, "_rate"}, int'(bus.rate_out), exp_rate);
    chk({tag, "_ndone"}, ndone, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk({tag, "_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.en       = 1'b0;
    bus.spike_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_count", int'(bus.count_out), 0);
    chk("rst_rate", int'(bus.rate_out), 0);
    rst = 1'b0;

    // spikes in IDLE are ignored
    ndone = 0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_ndone", ndone, 0);

    window(0, 0, 0, "zero");
    window(1, 256, 15, "full");
    window(4, 64, 4, "q4");
    window(2, 128, 8, "q2");
    window(3, 86, 5, "q3");

    // en toggling, spike on every cycle
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 510; i++) cyc(1'b0, (i % 2) == 0, 1'b1);
    chk("en_early", int'(bus.done), 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("en_done", int'(bus.done), 1);
    chk("en_count", int'(bus.count_out), 256);
    chk("en_ndone", ndone, 1);

    // spikes only on en=0 cycles are not counted
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 511; i++) cyc(1'b0, (i % 2) == 0, (i % 2) == 1);
    chk("en0_done", int'(bus.done), 1);
    chk("en0_count", int'(bus.count_out), 0);
    chk("en0_rate", int'(bus.rate_out), 0);

    // restart mid-window discards the partial count
    window(1, 256, 15, "pre");
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 155; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("rs_nodone", ndone, 0);
    for (int i = 0; i < 101; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("rs_done", int'(bus.done), 1);
    chk("rs_count", int'(bus.count_out), 0);
    chk("rs_ndone", ndone, 1);

    // start on the Nth sample wins over done
    window(2, 128, 8, "pre2");
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 255; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("col_done", int'(bus.done), 0);
    chk("col_busy", int'(bus.busy), 1);
    chk("col_count", int'(bus.count_out), 128);
    chk("col_rate", int'(bus.rate_out), 8);
    for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, (i % 4) == 0);
    chk("col_next_count", int'(bus.count_out), 64);
    chk("col_ndone", ndone, 1);

    // async reset mid-window
    window(2, 128, 8, "pre3");
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_count", int'(bus.count_out), 0);
    chk("arst_rate", int'(bus.rate_out), 0);
    chk("arst_done", int'(bus.done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("arst_ndone", ndone, 0);
    chk("arst_idle", int'(bus.busy), 0);

`ifdef SPIKE_RATE_DEC_CONT_EN
    ndone = 0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 768; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (i % 256 == 255) begin
        chk("cont_done", int'(bus.done), 1);
        chk("cont_count", int'(bus.count_out), 256);
        chk("cont_busy", int'(bus.busy), 1);
      end
    end
    chk("cont_ndone", ndone, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
